// File: rtl/status_reg_bank_sticky.sv
// status_reg_bank_sticky: IPbus status bank with sticky W1C errors, saturating trigger counters and timestamp snapshot
module status_reg_bank_sticky #(
  parameter int N_CHAN = 5,
  parameter int CNT_W  = 24,
  parameter int ERR_W  = 16,
  parameter int TS_W   = 44,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ipb_strobe,
  input  logic              ipb_write,
  input  logic [ADDR_W-1:0] ipb_addr,
  input  logic [31:0]       ipb_wdata,
  output logic [31:0]       ipb_rdata,
  output logic              ipb_ack,
  input  logic [31:0]       live_status,
  input  logic [ERR_W-1:0]  error_in,
  input  logic [N_CHAN-1:0] chan_trig,
  input  logic [TS_W-1:0]   trig_timestamp,
  output logic              counters_frozen
);
  logic accept, wr, w_err, w_ctl, clr, frz_eff, freeze, unused_wdata;
  logic [ERR_W-1:0] sticky;
  logic [TS_W-33:0] ts_hi;
  logic [CNT_W-1:0] cnt [N_CHAN];
  logic [31:0] rd;
  assign accept = ipb_strobe & ~ipb_ack;
  assign wr = accept & ipb_write;
  assign w_err = wr && ipb_addr == ADDR_W'(1);
  assign w_ctl = wr && ipb_addr == ADDR_W'(5);
  assign clr = w_ctl & ipb_wdata[0];
  // a freeze write gates triggers on its own accept edge
  assign frz_eff = w_ctl ? ipb_wdata[1] : freeze;
  assign counters_frozen = freeze;
  assign unused_wdata = ^ipb_wdata;
  always_comb begin
    rd = 32'hBAD0_ADD0;
    case (ipb_addr)
      ADDR_W'(0): rd = live_status;
      ADDR_W'(1): rd = 32'(sticky);
      ADDR_W'(2): rd = 32'(error_in);
      ADDR_W'(3): rd = trig_timestamp[31:0];
      ADDR_W'(4): rd = 32'(ts_hi);
      ADDR_W'(5): rd = {30'd0, freeze, 1'b0};
      ADDR_W'(6), ADDR_W'(7): rd = '0;
      default: for (int i = 0; i < N_CHAN; i++) if (ipb_addr == ADDR_W'(8 + i)) rd = 32'(cnt[i]);
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ipb_ack   <= 1'b0;
      ipb_rdata <= '0;
      sticky    <= '0;
      freeze    <= 1'b0;
      ts_hi     <= '0;
    end else begin
      ipb_ack <= accept;
      if (accept) ipb_rdata <= rd;
      sticky <= (sticky & ~(w_err ? ipb_wdata[ERR_W-1:0] : '0)) | error_in;
      if (w_ctl) freeze <= ipb_wdata[1];
      if (accept && !ipb_write && ipb_addr == ADDR_W'(3)) ts_hi <= trig_timestamp[TS_W-1:32];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CHAN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++)
        if (clr) cnt[i] <= '0;
        else if (chan_trig[i] && !frz_eff && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
  end
endmodule

// File: tb/tb_status_reg_bank_sticky.sv
// tb_status_reg_bank_sticky: table vectors plus scoreboard queue checking of the status bank
module tb_status_reg_bank_sticky;
  logic clk = 0, reset_n = 0, ipb_strobe = 0, ipb_write = 0;
  logic [5:0] ipb_addr = '0;
  logic [31:0] ipb_wdata = '0, live_status = 32'hCAFE_F00D;
  logic [15:0] error_in = '0;
  logic [4:0] chan_trig = '0;
  logic [43:0] trig_timestamp = '0;
  logic [31:0] ipb_rdata, rdata_s;
  logic ipb_ack, ack_s, counters_frozen, frozen_s;
  int checks = 0, errors = 0;
  typedef struct {logic [5:0] a; logic [31:0] rd; logic [31:0] rd_s; bit chk; bit chk_s;} exp_t;
  typedef struct {logic [5:0] a; logic w; logic [31:0] d; logic [31:0] e;} vec_t;
  exp_t q[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  status_reg_bank_sticky dut (
    .clk(clk), .reset_n(reset_n), .ipb_strobe(ipb_strobe), .ipb_write(ipb_write),
    .ipb_addr(ipb_addr), .ipb_wdata(ipb_wdata), .ipb_rdata(ipb_rdata), .ipb_ack(ipb_ack),
    .live_status(live_status), .error_in(error_in), .chan_trig(chan_trig),
    .trig_timestamp(trig_timestamp), .counters_frozen(counters_frozen));

  status_reg_bank_sticky #(.CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .ipb_strobe(ipb_strobe), .ipb_write(ipb_write),
    .ipb_addr(ipb_addr), .ipb_wdata(ipb_wdata), .ipb_rdata(rdata_s), .ipb_ack(ack_s),
    .live_status(live_status), .error_in(error_in), .chan_trig(chan_trig),
    .trig_timestamp(trig_timestamp), .counters_frozen(frozen_s));

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  always @(negedge clk) if (ipb_ack) begin
    exp_t x;
    if (q.size() == 0) check("spurious_ack", 32'd1, 32'd0);
    else begin
      x = q.pop_front();
      if (x.chk) check($sformatf("rd_a%0h", x.a), ipb_rdata, x.rd);
      if (x.chk_s) check($sformatf("rds_a%0h", x.a), rdata_s, x.rd_s);
    end
  end

  task automatic xact(input logic [5:0] a, input logic w, input logic [31:0] d, input logic [31:0] e,
                      input logic [4:0] trig = '0, input logic [15:0] err = '0,
                      input logic [31:0] es = '0, input bit cs = 0);
    @(negedge clk);
    ipb_strobe = 1; ipb_write = w; ipb_addr = a; ipb_wdata = d; chan_trig = trig; error_in = err;
    q.push_back('{a, e, es, !w, cs});
    @(posedge clk);
    #1 ipb_strobe = 0; ipb_write = 0; chan_trig = '0; error_in = '0;
    @(negedge clk);
    check("ack_latency", {31'd0, ipb_ack}, 32'd1);
    if (!ipb_ack) q.delete();
    @(negedge clk);
    check("ack_pulse", {31'd0, ipb_ack}, 32'd0);
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      @(negedge clk); chan_trig[ch] = 1'b1;
      @(negedge clk); chan_trig[ch] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'd5,  1'b0, 32'h0, 32'h0};
    vecs[1]  = '{6'd0,  1'b0, 32'h0, 32'hCAFE_F00D};
    vecs[2]  = '{6'd1,  1'b0, 32'h0, 32'h0};
    vecs[3]  = '{6'd2,  1'b0, 32'h0, 32'h0};
    vecs[4]  = '{6'd4,  1'b0, 32'h0, 32'h0};
    vecs[5]  = '{6'd6,  1'b0, 32'h0, 32'h0};
    vecs[6]  = '{6'd7,  1'b0, 32'h0, 32'h0};
    vecs[7]  = '{6'd12, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{6'd13, 1'b0, 32'h0, 32'hBAD0_ADD0};
    vecs[9]  = '{6'd0,  1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{6'd6,  1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{6'd6,  1'b0, 32'h0, 32'h0};
    // reset held with strobe high, first read accepted on release
    ipb_strobe = 1; ipb_addr = 6'd8;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ipb_ack}, 32'd0);
    check("rst_rdata", ipb_rdata, 32'd0);
    check("rst_frozen", {31'd0, counters_frozen}, 32'd0);
    q.push_back('{6'd8, 32'd0, 32'd0, 1'b1, 1'b1});
    reset_n = 1;
    @(posedge clk);
    #1 ipb_strobe = 0;
    @(negedge clk);
    check("ack_latency", {31'd0, ipb_ack}, 32'd1);
    @(negedge clk);
    check("ack_pulse", {31'd0, ipb_ack}, 32'd0);
    foreach (vecs[i]) xact(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].e);
    // counters and saturation in the CNT_W=4 instance
    pulse(2, 7);
    xact(6'd10, 0, 0, 32'd7, 0, 0, 32'd7, 1);
    pulse(2, 20);
    xact(6'd10, 0, 0, 32'd27, 0, 0, 32'd15, 1);
    // sticky errors
    @(negedge clk); error_in = 16'h8;
    @(negedge clk); error_in = 16'h0;
    xact(6'd1, 0, 0, 32'h8);
    xact(6'd2, 0, 0, 32'h0);
    xact(6'd2, 0, 0, 32'h8, 0, 16'h8);
    xact(6'd1, 1, 32'h8, 0, 0, 16'h8);
    xact(6'd1, 0, 0, 32'h8);
    xact(6'd1, 1, 32'h8, 0);
    xact(6'd1, 0, 0, 32'h0);
    @(negedge clk); error_in = 16'h0108;
    @(negedge clk); error_in = 16'h0;
    xact(6'd1, 1, 32'h8, 0);
    xact(6'd1, 0, 0, 32'h100);
    xact(6'd1, 1, 32'hFFFF_FFFF, 0);
    xact(6'd1, 0, 0, 32'h0);
    // timestamp snapshot
    trig_timestamp = 44'h0AB_CDEF_1234;
    xact(6'd3, 0, 0, 32'hCDEF_1234);
    trig_timestamp = 44'h0FF_FFFF_FFFF;
    xact(6'd4, 0, 0, 32'hAB);
    xact(6'd4, 0, 0, 32'hAB);
    // freeze and clear
    pulse(0, 3);
    xact(6'd8, 0, 0, 32'd3);
    xact(6'd5, 1, 32'h2, 0, 5'b00001);
    check("frozen_on", {31'd0, counters_frozen}, 32'd1);
    pulse(0, 5);
    xact(6'd8, 0, 0, 32'd3);
    xact(6'd5, 0, 0, 32'h2);
    xact(6'd5, 1, 32'h1, 0, 5'b00001);
    xact(6'd8, 0, 0, 32'd0);
    xact(6'd5, 0, 0, 32'h0);
    check("frozen_off", {31'd0, counters_frozen}, 32'd0);
    pulse(1, 2);
    xact(6'd9, 0, 0, 32'd2);
    xact(6'd5, 1, 32'h2, 0);
    xact(6'd5, 1, 32'h3, 0);
    xact(6'd9, 0, 0, 32'd0);
    xact(6'd5, 0, 0, 32'h2);
    xact(6'd5, 1, 32'h0, 0);
    pulse(1, 1);
    xact(6'd9, 0, 0, 32'd1);
    xact(6'h3F, 0, 0, 32'hBAD0_ADD0);
    // strobe held: one transaction every two cycles
    @(negedge clk);
    ipb_strobe = 1; ipb_addr = 6'd0;
    q.push_back('{6'd0, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0});
    q.push_back('{6'd0, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0});
    repeat (4) @(negedge clk);
    ipb_strobe = 0;
    repeat (2) @(negedge clk);
    check("held_strobe_acks", q.size(), 0);
    // reset between accept and ack
    @(negedge clk); error_in = 16'h4;
    @(negedge clk); error_in = 16'h0;
    pulse(3, 2);
    xact(6'd5, 1, 32'h2, 0);
    trig_timestamp = 44'h123_0000_0000;
    xact(6'd3, 0, 0, 32'h0);
    xact(6'd4, 0, 0, 32'h123);
    @(negedge clk);
    ipb_strobe = 1; ipb_addr = 6'd11;
    @(posedge clk);
    #1 ipb_strobe = 0; reset_n = 0;
    @(negedge clk);
    check("mid_rst_ack", {31'd0, ipb_ack}, 32'd0);
    check("mid_rst_frozen", {31'd0, counters_frozen}, 32'd0);
    @(negedge clk); reset_n = 1;
    xact(6'd1, 0, 0, 32'h0);
    xact(6'd11, 0, 0, 32'h0);
    xact(6'd5, 0, 0, 32'h0);
    xact(6'd4, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    check("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
